// File: rtl/maze_memory.sv
// rtl/maze_memory.sv - wall/path bitmap responder for the maze solver with host load and dump streams
//
// Purpose:
//   Holds a 2^maze_width x 2^maze_width wall bitmap loaded by a host over a
//   valid/ready stream, answers solver reads (1-cycle latency), records solver
//   writes in a separate path bitmap, and streams the path bitmap back to the
//   host once the solver signals done.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load_start      host pulse starting a new maze load (honoured in IDLE only)
//   load_valid      host cell valid
//   load_data       host cell value, 1 = wall
//   load_ready      high while loading; a cell is taken on load_valid & load_ready
//   load_done       one-cycle pulse after the final cell is accepted
//   row, col        solver cell index, address = row * 2^maze_width + col
//   maze_oe         solver read enable, maze_in updates on that edge
//   maze_we         solver write enable, marks the cell in the path bitmap
//   maze_in         registered wall bit returned to the solver
//   done            solver exit found, moves SERVE to DUMP
//   dump_valid      path bit available to the host
//   dump_ready      host accepts the path bit
//   dump_data       path bit of the current raster cell
//   dump_last       high together with the final raster cell
//   path_count      number of distinct cells the solver has marked
//   err_wall_write  sticky flag: solver marked a wall cell
//   busy            high in LOAD, SERVE and DUMP

module maze_memory #(
    parameter int maze_width = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic                      load_valid,
    input  logic                      load_data,
    output logic                      load_ready,
    output logic                      load_done,
    input  logic [maze_width-1:0]     row,
    input  logic [maze_width-1:0]     col,
    input  logic                      maze_oe,
    input  logic                      maze_we,
    output logic                      maze_in,
    input  logic                      done,
    output logic                      dump_valid,
    input  logic                      dump_ready,
    output logic                      dump_data,
    output logic                      dump_last,
    output logic [2*maze_width:0]     path_count,
    output logic                      err_wall_write,
    output logic                      busy
);

    localparam int AW    = 2 * maze_width;
    localparam int CELLS = 1 << AW;
    localparam int PC_W  = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SERVE = 2'd2,
        S_DUMP  = 2'd3
    } state_t;

    state_t            state_q;
    // One raster counter serves both LOAD and DUMP; the two states never overlap.
    logic [AW-1:0]     addr_q;
    logic              load_done_q;
    logic              maze_in_q;
    logic              dump_valid_q;
    logic              dump_data_q;
    logic              dump_last_q;
    logic [PC_W-1:0]   path_count_q;
    logic              err_q;

    logic              wall_mem [CELLS];
    logic              path_mem [CELLS];

    logic [AW-1:0]     cell_addr;
    logic              cell_wall;
    logic              cell_path;
    logic              dump_src;
    logic              dump_adv;

    assign cell_addr = {row, col};
    assign cell_wall = wall_mem[cell_addr];
    assign cell_path = path_mem[cell_addr];
    assign dump_src  = path_mem[addr_q];

    // The dump output register refills whenever it is empty or being consumed,
    // which gives one cell per cycle while dump_ready stays high and freezes
    // data/last while the host stalls.
    assign dump_adv  = !dump_valid_q || dump_ready;

    // Bitmap storage: never cleared by reset, only rewritten by a load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_LOAD && load_valid) begin
                wall_mem[addr_q] <= load_data;
                path_mem[addr_q] <= 1'b0;
            end
            if (state_q == S_SERVE && maze_we) begin
                path_mem[cell_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            load_done_q  <= 1'b0;
            maze_in_q    <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= 1'b0;
            dump_last_q  <= 1'b0;
            path_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_start) begin
                        state_q      <= S_LOAD;
                        addr_q       <= '0;
                        path_count_q <= '0;
                        err_q        <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (load_valid) begin
                        addr_q <= addr_q + AW'(1);
                        if (addr_q == '1) begin
                            load_done_q <= 1'b1;
                            state_q     <= S_SERVE;
                        end
                    end
                end

                S_SERVE: begin
                    if (maze_oe) begin
                        maze_in_q <= cell_wall;
                    end
                    if (maze_we) begin
                        // Only a first mark of a cell is counted.
                        if (!cell_path) begin
                            path_count_q <= path_count_q + PC_W'(1);
                        end
                        if (cell_wall) begin
                            err_q <= 1'b1;
                        end
                    end
                    if (done) begin
                        state_q      <= S_DUMP;
                        addr_q       <= '0;
                        dump_valid_q <= 1'b0;
                        dump_last_q  <= 1'b0;
                    end
                end

                S_DUMP: begin
                    if (dump_adv) begin
                        if (dump_valid_q && dump_last_q) begin
                            // Final cell handed over.
                            state_q      <= S_IDLE;
                            dump_valid_q <= 1'b0;
                            dump_data_q  <= 1'b0;
                            dump_last_q  <= 1'b0;
                        end else begin
                            dump_valid_q <= 1'b1;
                            dump_data_q  <= dump_src;
                            dump_last_q  <= (addr_q == '1);
                            addr_q       <= addr_q + AW'(1);
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign load_ready     = (state_q == S_LOAD);
    assign busy           = (state_q != S_IDLE);
    assign load_done      = load_done_q;
    assign maze_in        = maze_in_q;
    assign dump_valid     = dump_valid_q;
    assign dump_data      = dump_data_q;
    assign dump_last      = dump_last_q;
    assign path_count     = path_count_q;
    assign err_wall_write = err_q;

endmodule

// File: tb/tb_maze_memory.sv
// tb/tb_maze_memory.sv - self-checking bench for maze_memory

module tb_maze_memory;

    localparam int MW = 6;
    localparam int N  = 1 << (2 * MW);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_data = 1'b0;
    logic          load_ready;
    logic          load_done;
    logic [MW-1:0] row = '0;
    logic [MW-1:0] col = '0;
    logic          maze_oe = 1'b0;
    logic          maze_we = 1'b0;
    logic          maze_in;
    logic          done = 1'b0;
    logic          dump_valid;
    logic          dump_ready = 1'b0;
    logic          dump_data;
    logic          dump_last;
    logic [2*MW:0] path_count;
    logic          err_wall_write;
    logic          busy;

    maze_memory #(.maze_width(MW)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_done(load_done),
        .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we),
        .maze_in(maze_in), .done(done),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_last(dump_last),
        .path_count(path_count), .err_wall_write(err_wall_write), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit       oe;
        bit       we;
        bit [5:0] r;
        bit [5:0] c;
        bit       dn;
        bit       mi;
        int       pc;
        bit       err;
    } vec_t;

    vec_t vecs[12];
    bit   exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(int oe, int we, int r, int c, int dn, int mi, int pc, int err);
        vec_t v;
        v.oe = oe[0]; v.we = we[0]; v.r = r[5:0]; v.c = c[5:0];
        v.dn = dn[0]; v.mi = mi[0]; v.pc = pc; v.err = err[0];
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, " load_ready"}, int'(load_ready), 0);
        chk({tag, " load_done"}, int'(load_done), 0);
        chk({tag, " maze_in"}, int'(maze_in), 0);
        chk({tag, " dump_valid"}, int'(dump_valid), 0);
        chk({tag, " dump_data"}, int'(dump_data), 0);
        chk({tag, " dump_last"}, int'(dump_last), 0);
        chk({tag, " path_count"}, int'(path_count), 0);
        chk({tag, " err_wall_write"}, int'(err_wall_write), 0);
        chk({tag, " busy"}, int'(busy), 0);
    endtask

    task automatic serve_read(input int r, input int c, input bit exp, input string name);
        bit e;
        maze_oe = 1'b1; row = r[5:0]; col = c[5:0];
        exp_q.push_back(exp);
        tick;
        maze_oe = 1'b0;
        e = exp_q.pop_front();
        chk(name, int'(maze_in), int'(e));
    endtask

    initial begin
        int ready_cnt, done_early, idx, cyc, acc;
        int data_err, last_err, stab_err, bubble, stalls;
        bit got_first, prev_stall, pd, pl, e, exp_bit;

        // (5,7) = index 327 free, (10,10) = index 650 wall
        vecs[0]  = mk(1, 0,  5,  7, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0,  5,  8, 0, 1, 0, 0);
        vecs[2]  = mk(0, 0,  0,  0, 0, 1, 0, 0);
        vecs[3]  = mk(0, 0,  5,  7, 0, 1, 0, 0);
        vecs[4]  = mk(0, 1,  5,  7, 0, 1, 1, 0);
        vecs[5]  = mk(0, 1,  5,  7, 0, 1, 1, 0);
        vecs[6]  = mk(0, 1, 10, 10, 0, 1, 2, 1);
        vecs[7]  = mk(1, 1,  5,  7, 0, 0, 2, 1);
        vecs[8]  = mk(0, 0,  0,  0, 0, 0, 2, 1);
        vecs[9]  = mk(1, 0,  0,  0, 0, 1, 2, 1);
        vecs[10] = mk(1, 0,  5,  7, 0, 0, 2, 1);
        vecs[11] = mk(1, 0, 63, 63, 1, 1, 2, 1);

        repeat (3) tick;
        rst = 1'b0;
        check_all_zero("reset");

        // First load: all walls except (5,7)
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        load_valid = 1'b1;
        ready_cnt = 0;
        done_early = 0;
        for (int i = 0; i < N; i++) begin
            load_data = (i != 327);
            if (load_ready) ready_cnt++;
            if (load_done) done_early++;
            tick;
        end
        load_valid = 1'b0;
        chk("load ready cycles", ready_cnt, N);
        chk("load_done early", done_early, 0);
        chk("load_done pulse", int'(load_done), 1);
        chk("load_ready after load", int'(load_ready), 0);
        tick;
        chk("load_done single", int'(load_done), 0);
        chk("busy in serve", int'(busy), 1);

        // Serve vectors with maze_in scoreboard
        for (int i = 0; i < 12; i++) begin
            maze_oe = vecs[i].oe;
            maze_we = vecs[i].we;
            row = vecs[i].r;
            col = vecs[i].c;
            done = vecs[i].dn;
            exp_q.push_back(vecs[i].mi);
            tick;
            e = exp_q.pop_front();
            chk($sformatf("vec%0d maze_in", i), int'(maze_in), int'(e));
            chk($sformatf("vec%0d path_count", i), int'(path_count), vecs[i].pc);
            chk($sformatf("vec%0d err", i), int'(err_wall_write), int'(vecs[i].err));
        end
        done = 1'b0;
        chk("dump entry valid", int'(dump_valid), 0);

        // Dump: toggled backpressure first half, ready held high second half.
        // Solver oe/we keep toggling between (5,7) and (0,0) and must be ignored.
        idx = 0; cyc = 0; got_first = 0; prev_stall = 0; pd = 0; pl = 0;
        data_err = 0; last_err = 0; stab_err = 0; bubble = 0; stalls = 0;
        maze_oe = 1'b1;
        maze_we = 1'b1;
        while (idx < N && cyc < 20000) begin
            if (!got_first && dump_valid) begin
                got_first = 1;
                chk("dump first valid within 2", int'(cyc <= 2), 1);
            end
            if (prev_stall && (!dump_valid || dump_data != pd || dump_last != pl)) stab_err++;
            if (idx > 2048 && !dump_valid) bubble++;
            dump_ready = (idx >= 2048) ? 1'b1 : (cyc % 2 == 0);
            row = (cyc % 2 == 0) ? 6'd5 : 6'd0;
            col = (cyc % 2 == 0) ? 6'd7 : 6'd0;
            if (dump_valid && dump_ready) begin
                exp_bit = (idx == 327 || idx == 650);
                if (dump_data != exp_bit) data_err++;
                if (dump_last != (idx == N - 1)) last_err++;
                idx++;
            end
            prev_stall = dump_valid && !dump_ready;
            if (prev_stall) stalls++;
            pd = dump_data;
            pl = dump_last;
            tick;
            cyc++;
        end
        maze_oe = 1'b0;
        maze_we = 1'b0;
        dump_ready = 1'b0;
        chk("dump transfers", idx, N);
        chk("dump data errors", data_err, 0);
        chk("dump last errors", last_err, 0);
        chk("dump stall stability errors", stab_err, 0);
        chk("dump stalls exercised", int'(stalls > 0), 1);
        chk("dump bubbles at full rate", bubble, 0);
        chk("after dump valid", int'(dump_valid), 0);
        chk("after dump last", int'(dump_last), 0);
        chk("after dump busy", int'(busy), 0);
        chk("after dump maze_in held", int'(maze_in), 1);
        chk("after dump path_count", int'(path_count), 2);

        // IDLE ignores reads
        maze_oe = 1'b1; row = 6'd5; col = 6'd7;
        tick;
        maze_oe = 1'b0;
        chk("idle read ignored", int'(maze_in), 1);

        // Reset in the middle of a load
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data = 1'b0;
        repeat (100) tick;
        chk("mid load busy", int'(busy), 1);
        load_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_all_zero("mid-load reset");

        // Reload: all free except (5,8)
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        load_valid = 1'b1;
        acc = 0;
        cyc = 0;
        while (!load_done && cyc < 6000) begin
            load_data = (acc == 328);
            if (load_ready) acc++;
            tick;
            cyc++;
        end
        load_valid = 1'b0;
        chk("reload accepted cells", acc, N);
        chk("reload load_done", int'(load_done), 1);
        chk("reload path_count", int'(path_count), 0);
        chk("reload err", int'(err_wall_write), 0);

        // load_start in SERVE is ignored
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        chk("serve load_start ignored", int'(load_ready), 0);
        serve_read(5, 8, 1'b1, "reload read (5,8)");
        serve_read(0, 0, 1'b0, "reload read (0,0)");
        serve_read(63, 63, 1'b0, "reload read (63,63)");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maze_memory.md
Name: maze_memory

Overview:
- Responder end of the maze access interface (row/col/maze_oe/maze_we/maze_in/done) driven by the maze solver.
- Holds a 2^maze_width x 2^maze_width wall bitmap, loaded by a host over a valid/ready stream.
- Answers solver reads with one-cycle latency and records solver writes in a separate path bitmap.
- After the solver raises done, streams the path bitmap back to the host.

Parameters:
maze_width, 6, index width of row/col; grid is 2^maze_width square (64x64 = 4096 cells at default)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
load_start  in  1  host pulse: begin loading a new maze
load_valid  in  1  host cell valid
load_data  in  1  host cell value (1 = wall, 0 = free)
load_ready  out  1  cell accepted when load_valid & load_ready
load_done  out  1  one-cycle pulse after the last cell is accepted
row  in  maze_width  solver row index
col  in  maze_width  solver column index
maze_oe  in  1  solver read enable (synchronous)
maze_we  in  1  solver write enable (synchronous)
maze_in  out  1  read response (wall bit) to solver
done  in  1  solver exit found (level)
dump_valid  out  1  path bit available
dump_ready  in  1  host accepts path bit
dump_data  out  1  path bit of current raster cell
dump_last  out  1  high with the final cell (index 2^(2*maze_width)-1)
path_count  out  2*maze_width+1  number of distinct cells marked by the solver
err_wall_write  out  1  sticky: solver wrote a wall cell
busy  out  1  high in LOAD, SERVE, DUMP

Behaviour:
- Cell address = row*2^maze_width + col (row-major raster); all indices are in range, no bounds check.
- States: IDLE, LOAD, SERVE, DUMP.
- Reset (any state, mid-operation included):
  - State goes to IDLE.
  - All outputs and counters go to 0 (maze_in, load_ready, load_done, dump_*, path_count, err_wall_write, busy).
  - Bitmap contents are not cleared.
- IDLE:
  - load_start -> LOAD, load address <= 0.
  - maze_oe/maze_we/done are ignored; maze_in holds.
- LOAD:
  - load_ready = 1.
  - On each accept: wall[addr] <= load_data, path[addr] <= 0, addr += 1.
  - Accepting cell 4095 -> load_done = 1 for the next cycle, state -> SERVE.
  - path_count and err_wall_write clear on entry to LOAD.
  - load_start in LOAD is ignored.
- SERVE, read:
  - A posedge with maze_oe = 1 sets maze_in <= wall[row][col]; the value is visible in the following cycle (1-cycle latency).
  - With maze_oe = 0, maze_in holds its last value.
- SERVE, write:
  - A posedge with maze_we = 1 sets path[row][col] <= 1.
  - path_count increments only if that path bit was 0 (re-marking does not count).
  - If wall[row][col] = 1, err_wall_write <= 1 (sticky until reset/LOAD); the path bit is still set.
- SERVE, simultaneous oe and we at the same or different cells: both take effect; the read returns the wall bit, which writes never modify.
- SERVE, done:
  - done = 1 sampled -> DUMP, dump address <= 0.
  - An oe/we in that same cycle is still serviced.
- DUMP:
  - dump_valid rises no later than 2 cycles after entry.
  - While dump_valid = 1 and dump_ready = 0, dump_data and dump_last stay stable.
  - Each dump_valid & dump_ready handshake advances the address.
  - Back-to-back transfers at 1 cell/cycle are required when dump_ready is held high.
  - dump_last = 1 exactly with cell 4095; its handshake -> IDLE, dump_valid = 0.
  - maze_oe/maze_we are ignored in DUMP.
- load_start in SERVE/DUMP is ignored.
- path_count width 13 at default; it cannot overflow (max 4096).

Test Plan:
- Load 4096 cells, all walls except (5,7)=0, with load_valid high continuously. Required: load_ready stays 1 for 4096 cycles; load_done pulses once on the following cycle; state is SERVE.
- Read: oe at (5,7) then oe at (5,8) on consecutive cycles. Required: maze_in = 0 then 1, each one cycle after its request; with oe low afterwards, maze_in holds 1.
- Writes: we at (5,7) twice, then at (10,10), where (10,10) is a wall. Required: path_count = 2; err_wall_write = 1 after the third write.
- Simultaneous: oe and we both at (5,7) in one cycle. Required: maze_in = 0 next cycle; path_count unchanged on a re-mark.
- Dump with backpressure: raise done, toggle dump_ready 1/0. Required: data stable while stalled; exactly 4096 transfers; a 1 appears only at raster indices 327 and 650; dump_last only on index 4095; IDLE afterward.
- Reset mid-LOAD after 100 cells, then reload. Required: all outputs 0 after reset; the second load needs a full 4096 cells; path_count = 0.
